// File: rtl/uart_fifo_bridge.sv
// Memory-mapped bridge between a simple valid/ready CPU bus and a byte UART core,
// with TX/RX FIFOs, sticky overflow/framing-error flags and a small TX launch FSM.
module uart_fifo_bridge #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tx_trigger,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  localparam logic [1:0] REG_DATA   = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;
  localparam logic [1:0] REG_CTRL   = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

  tx_state_t         tx_state;
  logic [7:0]        tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wptr, tx_rptr;
  logic [TX_CW-1:0]  tx_count;
  logic [7:0]        rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wptr, rx_rptr;
  logic [RX_CW-1:0]  rx_count;
  logic              ovf_sticky, err_sticky;

  logic [1:0]  reg_sel;
  logic        is_write, tx_full, tx_empty, rx_full, rx_nonempty;
  logic        stall, accept, tx_push, tx_pop, rx_pop, rx_push, ovf_set, ctrl_wr;
  logic [31:0] status_word, rd_val;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

  assign reg_sel     = mem_addr[3:2];
  assign is_write    = |mem_wstrb;
  assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty    = (tx_count == '0);
  assign rx_full     = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_nonempty = (rx_count != '0);

  // A DATA write into a full TX FIFO holds off until the FSM frees an entry.
  assign stall   = mem_valid && is_write && (reg_sel == REG_DATA) && tx_full;
  assign accept  = mem_valid && !mem_ready && !stall;
  assign tx_push = accept && is_write && (reg_sel == REG_DATA);
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty && !is_transmitting;
  assign rx_pop  = accept && !is_write && (reg_sel == REG_DATA) && rx_nonempty;
  // A same-cycle pop makes room, so a full RX FIFO still takes the byte.
  assign rx_push = received && (!rx_full || rx_pop);
  assign ovf_set = received && rx_full && !rx_pop;
  assign ctrl_wr = accept && is_write && (reg_sel == REG_CTRL);

  assign status_word = {26'h0, err_sticky, ovf_sticky, tx_full, tx_empty, rx_full, rx_nonempty};

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DATA:   rd_val = rx_nonempty ? {24'h0, rx_mem[rx_rptr]} : 32'h0;
      REG_STATUS: rd_val = status_word;
      default:    rd_val = '0;
    endcase
  end

  // FIFO storage carries no reset; occupancy is governed by the counters below.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= mem_wdata[7:0];
    if (rx_push) rx_mem[rx_wptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      tx_wptr    <= '0;
      tx_rptr    <= '0;
      tx_count   <= '0;
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      rx_count   <= '0;
      ovf_sticky <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_write) ? rd_val : 32'h0;

      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);

      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);

      // Set has priority over a coincident CTRL clear.
      if (ovf_set)                       ovf_sticky <= 1'b1;
      else if (ctrl_wr && mem_wdata[0])  ovf_sticky <= 1'b0;
      if (recv_error)                    err_sticky <= 1'b1;
      else if (ctrl_wr && mem_wdata[1])  err_sticky <= 1'b0;
    end
  end

  // TX launch FSM: the head byte is latched on entry to START, trigger is high in START.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state   <= TX_IDLE;
      tx_trigger <= 1'b0;
      tx_byte    <= '0;
    end else begin
      tx_trigger <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state   <= TX_START;
            tx_trigger <= 1'b1;
            tx_byte    <= tx_mem[tx_rptr];
          end
        end
        TX_START:     tx_state <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (is_transmitting) tx_state <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!is_transmitting) tx_state <= TX_IDLE;
        default:      tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomized self-checking bench for uart_fifo_bridge against a queue-based model
// of the register map, the FIFOs and the sticky flags, with a simple UART core model.
module tb_uart_fifo_bridge;

  localparam int unsigned TX_D = 4;
  localparam int unsigned RX_D = 8;
  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RSV = 32'hC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        tx_trigger;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        recv_error = 1'b0;

  uart_fifo_bridge #(.TX_DEPTH(TX_D), .RX_DEPTH(RX_D)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .tx_trigger(tx_trigger), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .received(received), .rx_byte(rx_byte), .recv_error(recv_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // UART core model: busy for busy_len cycles after each trigger, or forced busy.
  int   busy_len = 10;
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  always @(posedge clk) begin
    if (!reset_n)            busy_cnt <= 0;
    else if (tx_trigger)     busy_cnt <= busy_len;
    else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
  end
  assign is_transmitting = hold_busy || (busy_cnt != 0);

  // Reference model state.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_ovf = 1'b0;
  logic       m_err = 1'b0;
  int         trig_count = 0;

  // Every launched byte must be the oldest byte written and not yet sent.
  always @(negedge clk) begin
    if (reset_n && tx_trigger) begin
      trig_count++;
      check("tx_expected", 32'(txq.size() != 0), 32'd1);
      if (txq.size() != 0) check("tx_byte", 32'(tx_byte), 32'(txq.pop_front()));
    end
  end

  function automatic logic [31:0] rx_status();
    return {26'h0, m_err, m_ovf, 2'b00, rxq.size() == RX_D, rxq.size() != 0};
  endfunction

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb,
                          output logic [31:0] rd, output int cyc);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = strb;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_ready && cyc < 2000);
    if (!mem_ready) check("bus_timeout", 32'(mem_ready), 32'd1);
    rd = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic write_data(input logic [7:0] b, output int cyc);
    logic [31:0] rd;
    txq.push_back(b);
    bus_xfer(A_DATA, {24'hABCDEF, b}, 4'hF, rd, cyc);
  endtask

  task automatic write_ctrl(input logic [1:0] v);
    logic [31:0] rd;
    int cyc;
    bus_xfer(A_CTRL, {30'h0, v}, 4'h1, rd, cyc);
    if (v[0]) m_ovf = 1'b0;
    if (v[1]) m_err = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] rd);
    int cyc;
    bus_xfer(a, 32'hFFFF_FFFF, 4'h0, rd, cyc);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    read_reg(A_DATA, rd);
    exp = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
    check(tag, rd, exp);
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp, input logic [31:0] mask);
    logic [31:0] rd;
    read_reg(A_STAT, rd);
    check(tag, rd & mask, exp & mask);
  endtask

  task automatic rx_pulse(input logic [7:0] b, input logic e);
    @(negedge clk);
    received = 1'b1; rx_byte = b; recv_error = e;
    @(negedge clk);
    received = 1'b0; recv_error = 1'b0;
    if (rxq.size() < RX_D) rxq.push_back(b);
    else m_ovf = 1'b1;
    if (e) m_err = 1'b1;
  endtask

  task automatic wait_drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (txq.size() == 0 && !is_transmitting && !tx_trigger) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check("drain_timeout", 32'(quiet), 32'd3);
  endtask

  initial begin
    int cyc;
    int snap;
    logic [31:0] rd;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_tx_trigger", 32'(tx_trigger), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    reset_n = 1'b1;
    check_status("rst_status", 32'h04, 32'hFF);

    // Single byte with a 10-cycle busy core
    busy_len = 10;
    write_data(8'h41, cyc);
    check("wr_latency", 32'(cyc), 32'd1);
    wait_drain();
    check("single_trig_count", 32'(trig_count), 32'd1);
    check_status("single_status", 32'h04, 32'hFF);

    // Fill TX while core held busy; the extra write must stall
    hold_busy = 1'b1;
    busy_len = 4;
    for (int i = 0; i < TX_D; i++) begin
      write_data(8'h50 + 8'(i), cyc);
      check("fill_latency", 32'(cyc), 32'd1);
    end
    check_status("tx_full_status", 32'h08, 32'hFF);
    txq.push_back(8'h5F);
    fork
      bus_xfer(A_DATA, 32'h5F, 4'h1, rd, cyc);
      begin
        repeat (20) @(negedge clk);
        hold_busy = 1'b0;
      end
    join
    check("stall_held", 32'(cyc > 20), 32'd1);
    wait_drain();
    check("fill_trig_count", 32'(trig_count), 32'(TX_D + 2));

    // Two received bytes, then an underflowing read
    rx_pulse(8'h11, 1'b0);
    rx_pulse(8'h22, 1'b0);
    check_status("rx2_status", 32'h05, 32'hFF);
    read_data("rx_first");
    read_data("rx_second");
    read_reg(A_DATA, rd);
    check("rx_empty_read", rd, 32'h0);
    check_status("rx_empty_status", 32'h04, 32'hFF);

    // RX overflow, then clear
    for (int i = 0; i <= RX_D; i++) rx_pulse(8'h30 + 8'(i), 1'b0);
    check_status("ovf_status", 32'h17, 32'hFF);
    write_ctrl(2'b01);
    check_status("ovf_cleared", 32'h07, 32'hFF);

    // Pop and push in the same cycle on a full RX FIFO
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wstrb = 4'h0;
    received = 1'b1; rx_byte = 8'hEE;
    @(negedge clk);
    received = 1'b0; mem_valid = 1'b0;
    check("coinc_ready", 32'(mem_ready), 32'd1);
    check("coinc_rdata", mem_rdata, {24'h0, rxq.pop_front()});
    rxq.push_back(8'hEE);
    check_status("coinc_status", 32'h07, 32'hFF);
    while (rxq.size() != 0) read_data("rx_intact");

    // Framing error sticky, and set winning over a coincident clear
    rx_pulse(8'h77, 1'b1);
    check_status("err_status", 32'h25, 32'hFF);
    write_ctrl(2'b10);
    check_status("err_cleared", 32'h05, 32'hFF);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = A_CTRL; mem_wdata = 32'h3; mem_wstrb = 4'hF;
    received = 1'b1; rx_byte = 8'h78; recv_error = 1'b1;
    @(negedge clk);
    received = 1'b0; recv_error = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
    rxq.push_back(8'h78);
    m_err = 1'b1;
    check_status("err_set_wins", rx_status() | 32'h04, 32'hFF);
    write_ctrl(2'b11);
    while (rxq.size() != 0) read_data("rx_drain");

    // Randomized mix of bus and UART traffic
    for (int it = 0; it < 200; it++) begin
      busy_len = int'($urandom_range(1, 6));
      case ($urandom_range(0, 5))
        0: write_data(8'($urandom), cyc);
        1: read_data("rnd_data");
        2: rx_pulse(8'($urandom), ($urandom_range(0, 7) == 0));
        3: check_status("rnd_status", rx_status(), 32'h33);
        4: write_ctrl(2'($urandom));
        default: begin
          read_reg(($urandom_range(0, 1) != 0) ? A_CTRL : A_RSV, rd);
          check("rnd_zero_reg", rd, 32'h0);
        end
      endcase
    end
    wait_drain();
    write_ctrl(2'b11);
    while (rxq.size() != 0) read_data("rnd_drain");
    check_status("rnd_final", 32'h04, 32'hFF);

    // Reset during WAIT_DONE abandons the queued bytes
    busy_len = 60;
    for (int i = 0; i < 4; i++) write_data(8'hA0 + 8'(i), cyc);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    txq.delete();
    rxq.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
    reset_n = 1'b1;
    snap = trig_count;
    repeat (100) @(negedge clk);
    check("post_rst_no_trig", 32'(trig_count), 32'(snap));
    check_status("post_rst_status", 32'h04, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
